// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Front end of the ALU board demo. Synchronizes three push-buttons
//            (A, B, OP), optionally debounces them, and on each clean press
//            captures the switch bus into operand A, operand B or the
//            operation code. When all three registers hold user data, every
//            further load raises a one-cycle valid strobe for the ALU.
// Config   : `LOADER_DEBOUNCE_EN defined   -> per-button debounce counters
//            `LOADER_DEBOUNCE_EN undefined -> edge detect on synchronizer
//                                             output, DB_CYCLES ignored
// Ports    : clk          system clock, rising edge
//            i_rst_n      asynchronous active-low reset
//            i_sw         switch bus (NB_DATA), sampled unsynchronized
//            i_btn_a      load operand A (async, active-high)
//            i_btn_b      load operand B (async, active-high)
//            i_btn_op     load operation code (async, active-high)
//            o_datoA      registered operand A (signed)
//            o_datoB      registered operand B (signed)
//            o_operation  registered operation code (NB_OP)
//            o_loaded     sticky load flags {op, b, a}
//            o_valid      one-cycle strobe on a load once armed
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int DB_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic [NB_DATA-1:0]        i_sw,
    input  logic                      i_btn_a,
    input  logic                      i_btn_b,
    input  logic                      i_btn_op,
    output logic signed [NB_DATA-1:0] o_datoA,
    output logic signed [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]          o_operation,
    output logic [2:0]                o_loaded,
    output logic                      o_valid
);

    localparam int c_NB_BTN = 3;

    // Bit order everywhere: [0]=A, [1]=B, [2]=OP (matches o_loaded).
    logic [c_NB_BTN-1:0] w_btn_raw;
    logic [c_NB_BTN-1:0] r_sync1;
    logic [c_NB_BTN-1:0] r_sync2;
    logic [c_NB_BTN-1:0] w_level;
    logic [c_NB_BTN-1:0] r_level_hist;
    logic [c_NB_BTN-1:0] w_load;
    logic [2:0]          w_loaded_next;

    assign w_btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    // Illegal parameter combinations show up as this block in the hierarchy.
    if (DB_CYCLES < 1 || NB_OP > NB_DATA) begin : g_cfg_invalid
    end

    // Two-stage synchronizer for the asynchronous buttons.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < c_NB_BTN; gi++) begin : g_btn
`ifdef LOADER_DEBOUNCE_EN
        localparam int c_CNT_W = $clog2(DB_CYCLES + 1);
        // The flip happens on the edge that would bring the count to
        // DB_CYCLES, so the counter only ever holds 0..DB_CYCLES-1 and the
        // level changes after exactly DB_CYCLES differing samples.
        localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;

        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (r_sync2[gi] != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // Any sample matching the current level restarts the count,
                // so a bounce shorter than DB_CYCLES never flips the level.
                r_cnt <= '0;
            end
        end

        assign w_level[gi] = r_level;
`else
        assign w_level[gi] = r_sync2[gi];
`endif
    end

    // Rising edge of the (debounced) level is the load strobe.
    assign w_load        = w_level & ~r_level_hist;
    assign w_loaded_next = o_loaded | w_load;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_hist <= '0;
            o_datoA      <= '0;
            o_datoB      <= '0;
            o_operation  <= '0;
            o_loaded     <= '0;
            o_valid      <= 1'b0;
        end else begin
            r_level_hist <= w_level;
            // Simultaneous strobes all take the same switch sample.
            if (w_load[0]) begin
                o_datoA <= i_sw;
            end
            if (w_load[1]) begin
                o_datoB <= i_sw;
            end
            if (w_load[2]) begin
                o_operation <= i_sw[NB_OP-1:0];
            end
            o_loaded <= w_loaded_next;
            // Armed is judged on the post-load flags so the load that
            // completes the set already raises valid.
            o_valid  <= (|w_load) & (&w_loaded_next);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Self-checking bench for alu_operand_loader. A behavioural model
//            predicts every output each cycle from the raw button history
//            (debounce expressed as "last DB_CYCLES synchronized samples all
//            disagree with the current level"). Works with and without
//            `LOADER_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

    localparam int NB_DATA   = 8;
    localparam int NB_OP     = 6;
    localparam int DB_CYCLES = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int c_LAT = DB_CYCLES + 3;
`else
    localparam int c_LAT = 3;
`endif
    localparam logic [2:0] c_A  = 3'b001;
    localparam logic [2:0] c_B  = 3'b010;
    localparam logic [2:0] c_OP = 3'b100;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NB_DATA-1:0] sw;
    logic               btn_a, btn_b, btn_op;
    logic [NB_DATA-1:0] dato_a, dato_b;
    logic [NB_OP-1:0]   operation;
    logic [2:0]         loaded;
    logic               valid;

    alu_operand_loader #(
        .NB_DATA   (NB_DATA),
        .NB_OP     (NB_OP),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_sw        (sw),
        .i_btn_a     (btn_a),
        .i_btn_b     (btn_b),
        .i_btn_op    (btn_op),
        .o_datoA     (dato_a),
        .o_datoB     (dato_b),
        .o_operation (operation),
        .o_loaded    (loaded),
        .o_valid     (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;   // index of the last rising edge seen outside reset
    int n_valid  = 0;   // o_valid pulses observed
    int last_valid_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]         m_raw_prev;   // raw buttons sampled one edge ago
    logic [2:0]         m_win[$];     // last DB_CYCLES synchronized samples
    logic [2:0]         m_deb, m_deb_prev;
    logic [NB_DATA-1:0] m_a, m_b;
    logic [NB_OP-1:0]   m_op;
    logic [2:0]         m_loaded;
    logic               m_valid;

    task automatic model_reset();
        m_raw_prev = '0;
        m_win.delete();
        for (int k = 0; k < DB_CYCLES; k++) m_win.push_back(3'b000);
        m_deb = '0; m_deb_prev = '0;
        m_a = '0; m_b = '0; m_op = '0; m_loaded = '0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] raw, input logic [NB_DATA-1:0] swv);
        logic [2:0] load, s_now, deb_next;
        load  = m_deb & ~m_deb_prev;
        s_now = m_raw_prev;   // synchronizer output = raw two samples late
`ifdef LOADER_DEBOUNCE_EN
        for (int b = 0; b < 3; b++) begin
            bit all_diff = 1'b1;
            foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
            deb_next[b] = all_diff ? ~m_deb[b] : m_deb[b];
        end
`else
        deb_next = s_now;
`endif
        m_win.push_back(s_now);
        if (m_win.size() > DB_CYCLES) void'(m_win.pop_front());
        m_deb_prev = m_deb;
        m_deb      = deb_next;
        m_raw_prev = raw;
        if (load[0]) m_a  = swv;
        if (load[1]) m_b  = swv;
        if (load[2]) m_op = swv[NB_OP-1:0];
        m_loaded = m_loaded | load;
        m_valid  = (|load) && (&m_loaded);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [2:0] btn, input logic [NB_DATA-1:0] swv);
        @(negedge clk);
        {btn_op, btn_b, btn_a} = btn;
        sw = swv;
        @(posedge clk);
        model_step(btn, swv);
        cyc++;
        #1;
        check("dato_a",    dato_a,    m_a);
        check("dato_b",    dato_b,    m_b);
        check("operation", operation, m_op);
        check("loaded",    loaded,    m_loaded);
        check("valid",     valid,     m_valid);
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
    endtask

    task automatic press(input logic [2:0] btn, input logic [NB_DATA-1:0] swv);
        for (int k = 0; k < c_LAT + 2; k++) cycle(btn, swv);
        for (int k = 0; k < c_LAT + 2; k++) cycle(3'b000, swv);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases
    // it mid high phase so the next cycle() sees edge 1 after release.
    task automatic do_reset(input logic [2:0] btn_hold);
        @(negedge clk);
        #2;
        {btn_op, btn_b, btn_a} = btn_hold;
        rst_n = 1'b0;
        #1;
        check("rst_dato_a",    dato_a,    0);
        check("rst_dato_b",    dato_b,    0);
        check("rst_operation", operation, 0);
        check("rst_loaded",    loaded,    0);
        check("rst_valid",     valid,     0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int v0, e1;

    initial begin
        rst_n = 1'b0;
        sw = '0;
        {btn_op, btn_b, btn_a} = 3'b000;
        #1;
        check("init_loaded", loaded, 0);
        check("init_valid",  valid,  0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential load A, B, OP.
        v0 = n_valid;
        press(c_A, 8'h05);
        check("seq_loaded_a", loaded, 3'b001);
        press(c_B, 8'hFD);
        check("seq_loaded_b", loaded, 3'b011);
        check("seq_no_valid_before_arm", n_valid - v0, 0);
        press(c_OP, 8'h20);
        check("seq_loaded_op", loaded, 3'b111);
        check("seq_dato_a", dato_a, 8'h05);
        check("seq_dato_b", dato_b, 8'hFD);
        check("seq_operation", operation, 6'h20);
        check("seq_valid_count", n_valid - v0, 1);

        // Hold B for 50 cycles once armed: one pulse at the full latency.
        v0 = n_valid;
        e1 = cyc + 1;
        for (int k = 0; k < 50; k++) cycle(c_B, 8'h77);
        for (int k = 0; k < c_LAT + 2; k++) cycle(3'b000, 8'h77);
        check("hold_valid_count", n_valid - v0, 1);
        check("hold_valid_edge", last_valid_cyc - e1 + 1, c_LAT);
        check("hold_dato_b", dato_b, 8'h77);

        // Simultaneous A+B while armed: same sample, a single pulse.
        v0 = n_valid;
        press(c_A | c_B, 8'h5A);
        check("simul_armed_a", dato_a, 8'h5A);
        check("simul_armed_b", dato_b, 8'h5A);
        check("simul_armed_valid_count", n_valid - v0, 1);

        // Simultaneous A+B from reset.
        do_reset(3'b000);
        v0 = n_valid;
        press(c_A | c_B, 8'h3C);
        check("simul_a", dato_a, 8'h3C);
        check("simul_b", dato_b, 8'h3C);
        check("simul_loaded", loaded, 3'b011);
        check("simul_valid_count", n_valid - v0, 0);

`ifdef LOADER_DEBOUNCE_EN
        // Bounces shorter than DB_CYCLES never load.
        do_reset(3'b000);
        for (int k = 0; k < 3; k++) cycle(c_A, 8'h11);
        cycle(3'b000, 8'h11);
        for (int k = 0; k < 3; k++) cycle(c_A, 8'h11);
        for (int k = 0; k < c_LAT + 4; k++) cycle(3'b000, 8'h11);
        check("bounce_loaded", loaded, 3'b000);
        check("bounce_dato_a", dato_a, 8'h00);
`else
        // Single-cycle pulse loads exactly three edges later.
        do_reset(3'b000);
        cycle(c_OP, 8'h02);
        cycle(3'b000, 8'h00);
        check("pulse_op_edge2", operation, 6'h00);
        cycle(3'b000, 8'h02);
        check("pulse_op_edge3", operation, 6'h02);
        check("pulse_loaded", loaded, 3'b100);
        for (int k = 0; k < 4; k++) cycle(3'b000, 8'h00);
`endif

        // Reset mid-debounce with the button still held: fresh press after
        // release, full latency.
        do_reset(3'b000);
        cycle(c_A, 8'h44);
        cycle(c_A, 8'h44);
        do_reset(c_A);
        e1 = cyc + 1;
        for (int k = 0; k < c_LAT - 1; k++) cycle(c_A, 8'h66);
        check("held_rst_not_yet", loaded, 3'b000);
        cycle(c_A, 8'h66);
        check("held_rst_loaded", loaded, 3'b001);
        check("held_rst_dato_a", dato_a, 8'h66);
        for (int k = 0; k < c_LAT + 2; k++) cycle(3'b000, 8'h66);

        // Reset after arming: valid stays low until all three reload.
        press(c_B, 8'h01);
        press(c_OP, 8'h03);
        do_reset(3'b000);
        v0 = n_valid;
        press(c_A, 8'h81);
        press(c_B, 8'h82);
        check("rearm_no_valid", n_valid - v0, 0);
        press(c_OP, 8'hC3);
        check("rearm_valid", n_valid - v0, 1);
        check("rearm_operation", operation, 6'h03);

        // Randomized buttons (mix of short glitches and long holds),
        // switches and occasional resets, checked against the model.
        begin
            logic [2:0]         rb;
            logic [NB_DATA-1:0] rs;
            rb = '0;
            rs = '0;
            for (int k = 0; k < 1500; k++) begin
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
                if ($urandom_range(0, 3) == 0) rs = NB_DATA'($urandom);
                if ($urandom_range(0, 399) == 0) do_reset(rb);
                cycle(rb, rs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
